// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state, op encodings and carry helper for the serial adder
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Majority of three: the carry produced by a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_add_cell.sv
// rtl/serial_add_cell.sv - 1-bit full-adder cell with a registered carry
module serial_add_cell
    import serial_arith_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_val,
    input  logic enable,
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Carry register: load seeds the carry-in (1 for subtraction), enable advances one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            c <= 1'b0;
        end else if (load) begin
            c <= load_val;
        end else if (enable) begin
            c <= maj3(a, b, c);
        end
    end

    assign s = a ^ b ^ c;

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - sequences W-bit add/subtract through a bit-serial carry cell
module serial_add_sequencer
    import serial_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [CW-1:0]   cnt;
    logic            last_bit;
    logic            cell_load;
    logic            cell_en;
    logic            s;
    logic            c;
    logic            carry_next;

    assign last_bit   = (cnt == CW'(W - 1));
    // Carry that the cell will hold after this cycle's bit; on the MSB it is the carry out.
    assign carry_next = maj3(a_sh[0], b_sh[0], c);

    serial_add_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .load     (cell_load),
        .load_val (sub),
        .enable   (cell_en),
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .s        (s),
        .c        (c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cell_load  = 1'b0;
        cell_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    cell_load  = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                cell_en = 1'b1;
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers, bit counter, result assembly and flag capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh <= op_a;
                        b_sh <= (sub == OP_SUB) ? ~op_b : op_b;
                        cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    result <= {s, result[W-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (last_bit) begin
                        // c is the carry into the MSB here, carry_next the carry out of it.
                        carry_out <= carry_next;
                        overflow  <= c ^ carry_next;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - randomized self-checking bench against an arithmetic model
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_sequencer #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: integer add/subtract, unsigned compare for carry, signed range for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic co, output logic ov);
        int ua, ub, sa, sb, full;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        if (s) begin
            full = sa - sb;
            co   = (ua >= ub);
            r    = W'(ua - ub);
        end else begin
            full = sa + sb;
            co   = (ua + ub) >= (1 << W);
            r    = W'(ua + ub);
        end
        ov = (full > (1 << (W - 1)) - 1) || (full < -(1 << (W - 1)));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < W + 6) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] er;
        logic         eco, eov;
        int           cyc;
        model(a, b, s, er, eco, eov);
        check("ready_before", ready, 1);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        check("busy_shift", busy, 1);
        wait_done(cyc);
        check("latency", cyc, W);
        check("result", result, er);
        check("carry_out", carry_out, eco);
        check("overflow", overflow, eov);
        @(posedge clk); #1;
        check("done_single", done, 0);
        check("ready_after", ready, 1);
    endtask

    initial begin
        int           cyc;
        int           dones;
        int           t;
        int           last_acc;
        int           n_done;
        logic         prev_done;
        logic [W-1:0] er;
        logic         eco, eov;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic         qs[$];
        logic [W-1:0] xa, xb;
        logic         xs;

        reset = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry_out, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic corners.
        run_op(8'h05, 8'h03, 1'b0);
        check("t1_const", result, 8'h08);
        run_op(8'h7F, 8'h01, 1'b0);
        check("t2_ovf_const", overflow, 1);
        run_op(8'hFF, 8'h01, 1'b0);
        check("t2_co_const", carry_out, 1);
        run_op(8'h03, 8'h05, 1'b1);
        check("t3_const", result, 8'hFE);
        run_op(8'h80, 8'h01, 1'b1);
        check("t3_ovf_const", overflow, 1);

        // Start pulse while busy must be ignored.
        op_a = 8'h05; op_b = 8'h03; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        op_a = 8'h11; op_b = 8'h22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check("busy_start_latency", cyc + 3, W);
        check("busy_start_result", result, 8'h08);
        dones = 0;
        repeat (3 * W) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("busy_start_no_2nd", dones, 0);
        check("busy_start_hold", result, 8'h08);
        check("busy_start_ready", ready, 1);

        // Reset in the middle of a shift.
        op_a = 8'h05; op_b = 8'h03; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_done", done, 0);
        dones = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_op(8'h01, 8'h01, 1'b0);
        check("midrst_new_op", result, 8'h02);

        // Back-to-back with start held high and inputs changing every cycle.
        @(negedge clk);
        start = 1'b1;
        last_acc = -1;
        n_done = 0;
        prev_done = 1'b0;
        t = 0;
        while (n_done < 1000 && t < 20000) begin
            if (done) begin
                check("b2b_done_pulse", prev_done, 0);
                if (qa.size() == 0) begin
                    check("b2b_spurious_done", 1, 0);
                end else begin
                    xa = qa.pop_front(); xb = qb.pop_front(); xs = qs.pop_front();
                    model(xa, xb, xs, er, eco, eov);
                    check("b2b_result", result, er);
                    check("b2b_carry", carry_out, eco);
                    check("b2b_ovf", overflow, eov);
                end
                n_done++;
            end
            prev_done = done;
            op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
            if (ready) begin
                if (last_acc >= 0) check("b2b_accept_gap", t - last_acc, W + 2);
                last_acc = t;
                qa.push_back(op_a); qb.push_back(op_b); qs.push_back(sub);
            end
            @(negedge clk);
            t++;
        end
        check("b2b_completed", n_done, 1000);
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Sequences a bit-serial two's-complement adder/subtractor over W-bit parallel operands. It accepts a start request and latches the operands. It then shifts them LSB-first through a 1-bit carry cell over W enabled cycles, reassembles the parallel result, and flags carry-out and signed overflow. It sits between a parallel requester (register file or test harness) and the serial arithmetic datapath.

Parameters:
W, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when ready=1.
sub  input  1  0 = A+B, 1 = A-B; sampled with start.
op_a  input  W  operand A, two's complement; sampled with start.
op_b  input  W  operand B, two's complement; sampled with start.
ready  output  1  high only in IDLE.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse; result, carry_out and overflow valid.
result  output  W  sum/difference; held from done until the next accepted start.
carry_out  output  1  carry out of MSB; for subtraction, 1 = no borrow.
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset values:
  - state=IDLE, ready=1, busy=0, done=0.
  - result=0, carry_out=0, overflow=0, bit counter=0, carry cell=0.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On start=1 (cycle T), latch A=op_a and B = sub ? ~op_b : op_b.
  - Load carry cell with sub. Clear counter. Go to SHIFT.
  - With start=0, all outputs hold.
- SHIFT (W cycles, counter 0..W-1):
  - Each cycle the serial bit s = A[0]^B[0]^c.
  - Carry cell loads maj(A[0],B[0],c).
  - result <= {s, result[W-1:1]}.
  - A and B shift right by 1. Counter increments.
  - On counter==W-1, capture the pre-update carry as c_msb_in and the post-update carry as carry_out. Go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - overflow = c_msb_in ^ carry_out, registered so it is valid in the DONE cycle.
  - Next state is IDLE. ready=0 in DONE, so the earliest next accept is T+W+2.
- Latency: start accepted at edge T; done is high during the cycle after edge T+W; result is stable from that cycle.
- start while busy is ignored; no queuing and no effect on the in-flight operation.
- op_a, op_b and sub may change freely after acceptance.
- Reset mid-operation (any state): return to reset values on the next edge, with no done pulse. A later start begins a fresh operation.
- result/carry_out/overflow are not cleared by a new start until they are overwritten during SHIFT. Consumers must use the done qualifier.
- Counter width is $clog2(W). No wrap-around beyond W-1.

Decomposition:
- Shared package serial_arith_pkg:
  - State enum/localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Op encoding OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: serial_add_cell. It holds the 1-bit carry register and the combinational sum.
  - Ports: clk, reset, load, load_val, enable, a, b, s, c.
  - load has priority over enable.
- The sequencer owns the FSM, counter, shift registers and flag capture.

Test Plan:
1. W=8, op_a=0x05, op_b=0x03, sub=0, start at T -> done at T+9: result=0x08, carry_out=0, overflow=0.
2. op_a=0x7F, op_b=0x01, sub=0 -> result=0x80, carry_out=0, overflow=1. Then op_a=0xFF, op_b=0x01 -> result=0x00, carry_out=1, overflow=0.
3. sub=1, op_a=0x03, op_b=0x05 -> result=0xFE, carry_out=0, overflow=0. Then op_a=0x80, op_b=0x01 -> result=0x7F, carry_out=1, overflow=1.
4. Pulse start with 0x11+0x22 at T+3 during a busy 0x05+0x03 -> done only once, at T+9, result=0x08. ready rises at T+10 and the second op is never executed.
5. Assert reset at T+4 mid-SHIFT -> next cycle ready=1, busy=0, result=0, and no done pulse. A new start of 0x01+0x01 -> result=0x02 after 9 cycles.
6. Back-to-back: start held high continuously -> accepts at T and T+10 exactly. Each done is a single cycle, and result matches a golden model over 1000 random op_a/op_b/sub vectors.
